semaforo_ped_req: RTL

//  Pedestrian-button front end for tt_um_semaforo; sits directly upstream of the light controller FSM.

---
 rtl/semaforo_pkg.sv | 16 +
 rtl/semaforo_debounce.sv | 70 +++++++
 rtl/semaforo_ped_req.sv | 108 ++++++++++
 3 files changed

// File: rtl/semaforo_pkg.sv
// semaforo_pkg -- shared types and defaults for the pedestrian-request front end.
//   ped_state_t      : request FSM states (IDLE, REQ, SERVED)
//   DEB_CYC_DEFAULT  : default debounce length in sample_en pulses
//   CNT_W_DEFAULT    : default width of the served-request counter
package semaforo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SERVED = 2'd2
    } ped_state_t;

    localparam int DEB_CYC_DEFAULT = 16;
    localparam int CNT_W_DEFAULT   = 8;

endpackage

// File: rtl/semaforo_debounce.sv
// semaforo_debounce -- two-flop synchroniser plus sample-strobed debounce counter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   sample_en  : debounce sample strobe
//   btn_in     : raw asynchronous button
//   btn_db     : debounced level (registered)
//   press      : combinational; high when btn_db goes 0->1 on the coming edge
module semaforo_debounce
    import semaforo_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_in,
    output logic btn_db,
    output logic press
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          db_nx;

    // Plain flop chain, nothing in between, so the synchroniser stays clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    // Any agreement between s2 and btn_db restarts the count, so only an
    // uninterrupted run of DEB_CYC disagreeing samples moves btn_db.
    always_comb begin
        cnt_nx = cnt;
        db_nx  = btn_db;
        if (s2 == btn_db) begin
            cnt_nx = '0;
        end else if (sample_en) begin
            if (cnt == CW'(DEB_CYC - 1)) begin
                db_nx  = s2;
                cnt_nx = '0;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            btn_db <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            btn_db <= db_nx;
        end
    end

    // Taken from the next state so the FSM reacts on the same edge btn_db rises.
    assign press = db_nx & ~btn_db;

endmodule

// File: rtl/semaforo_ped_req.sv
// semaforo_ped_req -- pedestrian button front end for the traffic-light controller.
// Debounces the button, latches one walk request per press and holds req_o
// until the controller acknowledges with ack_i (walk phase active).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   sample_en   : debounce sample strobe (tie 1 to sample every clock)
//   btn_in      : raw pedestrian button, active-high
//   ack_i       : controller walk phase active (level)
//   req_o       : pending walk request (registered)
//   btn_db      : debounced button level (registered)
//   served_cnt  : saturating count of served requests
// Optional feature: define SEMAFORO_PED_COUNT_EN to build the served-request
// counter; otherwise served_cnt is tied to 0.
//
// Handshake: req_o rises on a press and stays high until ack_i is seen high;
// after that the request is considered served once ack_i returns low. A press
// seen while serving is remembered (pend) and re-raises req_o when ack_i drops.
module semaforo_ped_req
    import semaforo_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             btn_in,
    input  logic             ack_i,
    output logic             req_o,
    output logic             btn_db,
    output logic [CNT_W-1:0] served_cnt
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_REQ    = REQ;
    localparam logic [1:0] ST_SERVED = SERVED;

    logic       press;
    logic [1:0] state;
    logic [1:0] state_nx;
    logic       pend;
    logic       pend_nx;

    semaforo_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .btn_in    (btn_in),
        .btn_db    (btn_db),
        .press     (press)
    );

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        case (state)
            ST_IDLE: begin
                if (press) state_nx = ST_REQ;
            end
            ST_REQ: begin
                // A press coinciding with ack is absorbed by the request being served.
                if (ack_i) state_nx = ST_SERVED;
            end
            ST_SERVED: begin
                if (!ack_i) begin
                    state_nx = (pend || press) ? ST_REQ : ST_IDLE;
                    pend_nx  = 1'b0;
                end else if (press) begin
                    pend_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                pend_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pend  <= 1'b0;
            req_o <= 1'b0;
        end else begin
            state <= state_nx;
            pend  <= pend_nx;
            req_o <= (state_nx == ST_REQ);
        end
    end

`ifdef SEMAFORO_PED_COUNT_EN
    logic served_evt;
    assign served_evt = (state == ST_REQ) && (state_nx == ST_SERVED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_cnt <= '0;
        end else if (served_evt && (served_cnt != {CNT_W{1'b1}})) begin
            served_cnt <= served_cnt + CNT_W'(1);
        end
    end
`else
    assign served_cnt = '0;
`endif

endmodule
